tile_peak_detector: RTL

Streaming keypoint detector that sits after the corner-response stage and alongside the grayscale pixel stream. It partitions the frame into 2^TILE_LOG2-square tiles and tracks the strongest corner response per tile in raster order. At each tile's last pixel it emits one keypoint record (x, y, score) into an output FIFO if the score clears a threshold. It optionally overlays the previous frame's keypoints on the pixel stream for on-screen debug.

---
 rtl/tile_peak_detector.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tile_peak_detector.sv
// tile_peak_detector: tracks the strongest corner response per square tile and queues one keypoint per tile.
// Define TILE_PEAK_OVERLAY_EN to mark the previous frame's keypoints on pixout (8'hFF).
`timescale 1ns/1ps
module tile_peak_detector #(
  parameter int TILE_LOG2 = 6,
  parameter int TILES_X   = 10,
  parameter int TILES_Y   = 8,
  parameter int COORD_W   = 13,
  parameter int SCORE_W   = 8,
  parameter int THRESHOLD = 32,
  parameter int FIFO_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [7:0]         pix,
  input  logic [SCORE_W-1:0] corner,
  input  logic [COORD_W-1:0] col,
  input  logic [COORD_W-1:0] row,
  output logic [7:0]         pixout,
  output logic               kp_valid,
  input  logic               kp_ready,
  output logic [COORD_W-1:0] kp_x,
  output logic [COORD_W-1:0] kp_y,
  output logic [SCORE_W-1:0] kp_score,
  output logic               frame_done,
  output logic [7:0]         kp_count,
  output logic               overflow
);
  localparam int TX_W  = (TILES_X > 1) ? $clog2(TILES_X) : 1;
  localparam int HI_W  = COORD_W - TILE_LOG2;
  localparam int REC_W = 2 * COORD_W + SCORE_W;
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [TILE_LOG2-1:0] LAST_L  = '1;
  localparam logic [FIFO_LOG2:0]   PTR_ONE = (FIFO_LOG2 + 1)'(1);

  logic [HI_W-1:0]      tx, ty;
  logic [TILE_LOG2-1:0] lx, ly;
  logic [TX_W-1:0]      tx_idx;
  logic                 in_range, frame_start, tile_done, last_tile;

  assign tx          = col[COORD_W-1:TILE_LOG2];
  assign ty          = row[COORD_W-1:TILE_LOG2];
  assign lx          = col[TILE_LOG2-1:0];
  assign ly          = row[TILE_LOG2-1:0];
  assign tx_idx      = tx[TX_W-1:0];
  assign in_range    = en && (tx < HI_W'(TILES_X)) && (ty < HI_W'(TILES_Y));
  assign frame_start = in_range && (col == '0) && (row == '0);
  assign tile_done   = in_range && (lx == LAST_L) && (ly == LAST_L);
  assign last_tile   = tile_done && (tx == HI_W'(TILES_X - 1)) && (ty == HI_W'(TILES_Y - 1));

  // One accumulator per tile column; the raster scan only ever has one tile row open.
  logic [SCORE_W-1:0]   max_q  [TILES_X];
  logic [TILE_LOG2-1:0] argx_q [TILES_X];
  logic [TILE_LOG2-1:0] argy_q [TILES_X];

  logic [SCORE_W-1:0]   cur_max, cand_max;
  logic [TILE_LOG2-1:0] cur_x, cur_y, cand_x, cand_y;

  always_comb begin
    cur_max = frame_start ? '0 : max_q[tx_idx];
    cur_x   = frame_start ? '0 : argx_q[tx_idx];
    cur_y   = frame_start ? '0 : argy_q[tx_idx];
    // Strict compare so a tie keeps the earlier raster position.
    if (corner > cur_max) begin
      cand_max = corner;
      cand_x   = lx;
      cand_y   = ly;
    end else begin
      cand_max = cur_max;
      cand_x   = cur_x;
      cand_y   = cur_y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TILES_X; i++) begin
        max_q[i]  <= '0;
        argx_q[i] <= '0;
        argy_q[i] <= '0;
      end
    end else begin
      if (frame_start) begin
        for (int i = 0; i < TILES_X; i++) begin
          max_q[i]  <= '0;
          argx_q[i] <= '0;
          argy_q[i] <= '0;
        end
      end
      if (in_range) begin
        max_q[tx_idx]  <= tile_done ? '0 : cand_max;
        argx_q[tx_idx] <= tile_done ? '0 : cand_x;
        argy_q[tx_idx] <= tile_done ? '0 : cand_y;
      end
    end
  end

  // Keypoint FIFO, first-word fall-through. A record transfers on a cycle where
  // kp_valid && kp_ready at the rising edge; kp_* hold while kp_valid && !kp_ready.
  logic [REC_W-1:0]   mem_q [DEPTH];
  logic [FIFO_LOG2:0] wr_q, rd_q;
  logic [REC_W-1:0]   push_rec, head_rec;
  logic               fifo_empty, fifo_full, kp_push, pop, push_ok, drop;

  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[FIFO_LOG2] != rd_q[FIFO_LOG2]) &&
                      (wr_q[FIFO_LOG2-1:0] == rd_q[FIFO_LOG2-1:0]);
  assign kp_push    = tile_done && (cand_max > SCORE_W'(THRESHOLD));
  assign pop        = !fifo_empty && kp_ready;
  assign push_ok    = kp_push && (!fifo_full || pop);
  assign drop       = kp_push && !push_ok;
  assign push_rec   = {col[COORD_W-1:TILE_LOG2], cand_x, row[COORD_W-1:TILE_LOG2], cand_y, cand_max};
  assign head_rec   = fifo_empty ? '0 : mem_q[rd_q[FIFO_LOG2-1:0]];

  assign kp_valid = !fifo_empty;
  assign kp_x     = head_rec[REC_W-1 -: COORD_W];
  assign kp_y     = head_rec[SCORE_W +: COORD_W];
  assign kp_score = head_rec[SCORE_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q[FIFO_LOG2-1:0]] <= push_rec;
        wr_q <= wr_q + PTR_ONE;
      end
      if (pop) rd_q <= rd_q + PTR_ONE;
    end
  end

  logic [7:0] cnt_q, cnt_d, kp_count_q;
  logic       ovf_q, ovf_d, frame_done_q;

  always_comb begin
    cnt_d = frame_start ? 8'd0 : cnt_q;
    if (push_ok && (cnt_d != 8'hFF)) cnt_d = cnt_d + 8'd1;
    ovf_d = frame_start ? 1'b0 : ovf_q;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
      kp_count_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      frame_done_q <= last_tile;
      if (last_tile) kp_count_q <= cnt_d;
    end
  end

  assign frame_done = frame_done_q;
  assign kp_count   = kp_count_q;
  assign overflow   = ovf_q;

  logic [7:0] pixout_q, pixout_d;

`ifdef TILE_PEAK_OVERLAY_EN
  localparam int MAP_N = TILES_X * TILES_Y;
  localparam int MAP_W = (MAP_N > 1) ? $clog2(MAP_N) : 1;

  // Each entry is rewritten only at its tile's last pixel, so it shows last frame's peak.
  logic                 map_v_q [MAP_N];
  logic [TILE_LOG2-1:0] map_x_q [MAP_N];
  logic [TILE_LOG2-1:0] map_y_q [MAP_N];
  logic [MAP_W-1:0]     map_idx;
  logic                 ovl_hit;

  assign map_idx  = MAP_W'(ty * HI_W'(TILES_X) + tx);
  assign ovl_hit  = in_range && map_v_q[map_idx] && (map_x_q[map_idx] == lx) && (map_y_q[map_idx] == ly);
  assign pixout_d = ovl_hit ? 8'hFF : pix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAP_N; i++) begin
        map_v_q[i] <= 1'b0;
        map_x_q[i] <= '0;
        map_y_q[i] <= '0;
      end
    end else if (tile_done) begin
      map_v_q[map_idx] <= kp_push;
      map_x_q[map_idx] <= cand_x;
      map_y_q[map_idx] <= cand_y;
    end
  end
`else
  assign pixout_d = pix;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    pixout_q <= '0;
    else if (en) pixout_q <= pixout_d;
  end

  assign pixout = pixout_q;
endmodule
